// File: rtl/global_types.sv
// rtl/global_types.sv - shared stream types plus arbiter state and round-robin helper
package global_types;

    localparam int W   = 32;
    localparam int B   = 8;
    localparam int BpW = W / B;

    typedef struct packed {
        logic                       valid;
        logic                       sop;
        logic                       eop;
        logic [$clog2(BpW)-1:0]     empty;
        logic [W-1:0]               data;
    } avln_st;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // First set bit of req scanning upward from (last+1) mod n, wrapping; n <= 8.
    // Returns last when nothing is requesting, callers qualify with any_req.
    function automatic logic [2:0] rr_first(input logic [7:0] req,
                                            input logic [2:0] last,
                                            input int         n);
        logic [2:0] idx;
        logic       found;
        rr_first = last;
        found    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= n) begin
                idx = 3'((int'(last) + k) % n);
                if (!found && req[idx]) begin
                    rr_first = idx;
                    found    = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/avln_st_pkt_arbiter_rr_pick.sv
// rtl/avln_st_pkt_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick
    import global_types::*;
#(
    parameter  int N_SRC = 2,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    // Winner is the first requester after the previously served source.
    always_comb begin
        winner  = IDX_W'(rr_first(8'(req), 3'(last_grant), N_SRC));
        any_req = |req;
    end

endmodule

// File: rtl/avln_st_pkt_arbiter.sv
// rtl/avln_st_pkt_arbiter.sv - packet-granular round-robin Avalon-ST arbiter
module avln_st_pkt_arbiter
    import global_types::*;
#(
    parameter  int N_SRC = 2,
    parameter  int CNT_W = 16,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  avln_st           in_st [N_SRC],
    output logic [N_SRC-1:0] in_ready,
    output avln_st           out_st,
    input  logic             out_ready,
    output logic [IDX_W-1:0] grant,
    output logic             busy,
    output logic             proto_err,
    output logic [CNT_W-1:0] pkt_count
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] last_grant;
    logic [N_SRC-1:0] sop_req;
    logic [N_SRC-1:0] orphan;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             eop_done;

    // Split each source's head beat into packet starts and stray mid-packet beats.
    always_comb begin
        sop_req = '0;
        orphan  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            sop_req[i] = in_st[i].valid &  in_st[i].sop;
            orphan[i]  = in_st[i].valid & ~in_st[i].sop;
        end
    end

    rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
        .req        (sop_req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Next state and stream muxing; outputs are forced quiet while reset is held.
    always_comb begin
        state_d   = state_q;
        out_st    = '0;
        in_ready  = '0;
        proto_err = 1'b0;
        eop_done  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                in_ready  = orphan;
                proto_err = |orphan;
                if (any_req) begin
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                out_st            = in_st[grant_q];
                in_ready[grant_q] = out_ready;
                if (out_st.valid && out_ready && out_st.eop) begin
                    eop_done = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (!reset_n) begin
            in_ready     = '0;
            proto_err    = 1'b0;
            out_st.valid = 1'b0;
            eop_done     = 1'b0;
        end
    end

    // State, grant lock, round-robin pointer and forwarded-packet counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
            pkt_count  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && any_req) begin
                grant_q <= winner;
            end
            if (eop_done) begin
                last_grant <= grant_q;
                pkt_count  <= pkt_count + CNT_W'(1);
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_avln_st_pkt_arbiter.sv
// tb/tb_avln_st_pkt_arbiter.sv - directed vector bench for avln_st_pkt_arbiter
module tb_avln_st_pkt_arbiter;
    import global_types::*;

    localparam int N_SRC = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    avln_st           in_st [N_SRC];
    logic [N_SRC-1:0] in_ready;
    avln_st           out_st;
    logic             out_ready;
    logic [0:0]       grant;
    logic             busy;
    logic             proto_err;
    logic [CNT_W-1:0] pkt_count;

    int checks   = 0;
    int failures = 0;

    avln_st_pkt_arbiter #(.N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_st     (in_st),
        .in_ready  (in_ready),
        .out_st    (out_st),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy),
        .proto_err (proto_err),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0, s0, e0;
        logic [31:0] d0;
        logic        v1, s1, e1;
        logic [31:0] d1;
        logic        ordy;
        logic        ov, osop, oeop;
        logic [31:0] od;
        logic [1:0]  ir;
        logic        bsy;
        logic        g;
        logic        perr;
        logic [3:0]  pc;
    } vec_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    vec_t  vq [$];
    beat_t sq0 [$];
    beat_t sq1 [$];
    beat_t expq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v0, s0, e0, input logic [31:0] d0,
                       input logic v1, s1, e1, input logic [31:0] d1,
                       input logic ordy,
                       input logic ov, osop, oeop, input logic [31:0] od,
                       input logic [1:0] ir, input logic bsy, g, perr,
                       input logic [3:0] pc);
        vec_t v;
        v.v0 = v0; v.s0 = s0; v.e0 = e0; v.d0 = d0;
        v.v1 = v1; v.s1 = s1; v.e1 = e1; v.d1 = d1;
        v.ordy = ordy;
        v.ov = ov; v.osop = osop; v.oeop = oeop; v.od = od;
        v.ir = ir; v.bsy = bsy; v.g = g; v.perr = perr; v.pc = pc;
        vq.push_back(v);
    endtask

    task automatic drive(input int s, input logic v, sp, ep, input logic [31:0] d);
        in_st[s] = '{valid: v, sop: sp, eop: ep, empty: 2'b00, data: d};
    endtask

    task automatic run_vec(input int k, input string tag);
        vec_t v;
        v = vq[k];
        drive(0, v.v0, v.s0, v.e0, v.d0);
        drive(1, v.v1, v.s1, v.e1, v.d1);
        out_ready = v.ordy;
        @(negedge clk);
        chk($sformatf("%s%0d_valid", tag, k), 32'(out_st.valid), 32'(v.ov));
        if (v.ov) begin
            chk($sformatf("%s%0d_data", tag, k), out_st.data, v.od);
            chk($sformatf("%s%0d_sop", tag, k), 32'(out_st.sop), 32'(v.osop));
            chk($sformatf("%s%0d_eop", tag, k), 32'(out_st.eop), 32'(v.oeop));
        end
        chk($sformatf("%s%0d_in_ready", tag, k), 32'(in_ready), 32'(v.ir));
        chk($sformatf("%s%0d_busy", tag, k), 32'(busy), 32'(v.bsy));
        if (v.bsy) chk($sformatf("%s%0d_grant", tag, k), 32'(grant), 32'(v.g));
        chk($sformatf("%s%0d_proto_err", tag, k), 32'(proto_err), 32'(v.perr));
        chk($sformatf("%s%0d_pkt_count", tag, k), 32'(pkt_count), 32'(v.pc));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int oi;
        int cyc;
        logic pop0, pop1;

        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive(0, 1, 0, 0, 32'h5555);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_valid", 32'(out_st.valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        chk("rst_pkt_count", 32'(pkt_count), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 3-beat packet, orphan, backpressured packet with mid-packet sop and valid gap, single-beat packet
        add(1,1,0,32'h11, 0,0,0,0, 1, 0,0,0,0,        2'b00,0,0,0,0);
        add(1,1,0,32'h11, 0,0,0,0, 1, 1,1,0,32'h11,   2'b01,1,0,0,0);
        add(1,0,0,32'h22, 0,0,0,0, 1, 1,0,0,32'h22,   2'b01,1,0,0,0);
        add(1,0,1,32'h33, 0,0,0,0, 1, 1,0,1,32'h33,   2'b01,1,0,0,0);
        add(0,0,0,0,      0,0,0,0, 1, 0,0,0,0,        2'b00,0,0,0,1);
        add(1,0,0,32'hDEAD,0,0,0,0,1, 0,0,0,0,        2'b01,0,0,1,1);
        add(0,0,0,0,      0,0,0,0, 1, 0,0,0,0,        2'b00,0,0,0,1);
        add(0,0,0,0,      1,1,0,32'hA1, 1, 0,0,0,0,   2'b00,0,0,0,1);
        add(1,1,1,32'hB1, 1,1,0,32'hA1, 1, 1,1,0,32'hA1, 2'b10,1,1,0,1);
        add(1,1,1,32'hB1, 1,1,0,32'hA2, 0, 1,1,0,32'hA2, 2'b00,1,1,0,1);
        add(1,1,1,32'hB1, 1,1,0,32'hA2, 1, 1,1,0,32'hA2, 2'b10,1,1,0,1);
        add(1,1,1,32'hB1, 0,0,0,0,      1, 0,0,0,0,      2'b10,1,1,0,1);
        add(1,1,1,32'hB1, 1,0,1,32'hA3, 0, 1,0,1,32'hA3, 2'b00,1,1,0,1);
        add(1,1,1,32'hB1, 1,0,1,32'hA3, 1, 1,0,1,32'hA3, 2'b10,1,1,0,1);
        add(1,1,1,32'hB1, 0,0,0,0,      1, 0,0,0,0,      2'b00,0,0,0,2);
        add(1,1,1,32'hB1, 0,0,0,0,      1, 1,1,1,32'hB1, 2'b01,1,0,0,2);
        add(0,0,0,0,      0,0,0,0,      1, 0,0,0,0,      2'b00,0,0,0,3);
        for (int k = 0; k < vq.size(); k++) run_vec(k, "v");

        // Two contending sources, four 2-beat packets each: strict alternation from source 0
        do_reset();
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 2; s++) begin
                for (int b = 0; b < 2; b++) begin
                    beat_t bt;
                    bt.sop  = (b == 0);
                    bt.eop  = (b == 1);
                    bt.data = {16'h0, 4'(s), 4'(p), 8'(b)};
                    if (s == 0) sq0.push_back(bt); else sq1.push_back(bt);
                    expq.push_back(bt);
                end
            end
        end
        oi  = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (oi < 16 && cyc < 200) begin
            if (sq0.size() > 0) drive(0, 1, sq0[0].sop, sq0[0].eop, sq0[0].data);
            else                drive(0, 0, 0, 0, 0);
            if (sq1.size() > 0) drive(1, 1, sq1[0].sop, sq1[0].eop, sq1[0].data);
            else                drive(1, 0, 0, 0, 0);
            @(negedge clk);
            if (out_st.valid) begin
                chk($sformatf("rr_beat%0d_data", oi), out_st.data, expq[oi].data);
                chk($sformatf("rr_beat%0d_sop", oi), 32'(out_st.sop), 32'(expq[oi].sop));
                chk($sformatf("rr_beat%0d_eop", oi), 32'(out_st.eop), 32'(expq[oi].eop));
                oi++;
            end
            pop0 = in_ready[0] && in_st[0].valid;
            pop1 = in_ready[1] && in_st[1].valid;
            @(posedge clk);
            #1;
            if (pop0) void'(sq0.pop_front());
            if (pop1) void'(sq1.pop_front());
            cyc++;
        end
        chk("rr_beats_seen", 32'(oi), 16);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rr_pkt_count", 32'(pkt_count), 8);
        @(posedge clk);
        #1;

        // Reset after second of four beats, then a clean packet from source 1
        vq.delete();
        add(1,1,0,32'hC0, 0,0,0,0, 1, 0,0,0,0,      2'b00,0,0,0,8);
        add(1,1,0,32'hC0, 0,0,0,0, 1, 1,1,0,32'hC0, 2'b01,1,0,0,8);
        add(1,0,0,32'hC1, 0,0,0,0, 1, 1,0,0,32'hC1, 2'b01,1,0,0,8);
        for (int k = 0; k < 3; k++) run_vec(k, "pre");
        drive(0, 1, 0, 0, 32'hC2);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(out_st.valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_pkt_count", 32'(pkt_count), 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        vq.delete();
        add(0,0,0,0, 1,1,0,32'hD0, 1, 0,0,0,0,      2'b00,0,0,0,0);
        add(0,0,0,0, 1,1,0,32'hD0, 1, 1,1,0,32'hD0, 2'b10,1,1,0,0);
        add(0,0,0,0, 1,0,1,32'hD1, 1, 1,0,1,32'hD1, 2'b10,1,1,0,0);
        add(0,0,0,0, 0,0,0,0,      1, 0,0,0,0,      2'b00,0,0,0,1);
        for (int k = 0; k < 4; k++) run_vec(k, "post");

        // 17 single-beat packets on a 4-bit counter: wraps through zero to 1
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 1, 32'(i));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("wrap_pkt%0d_valid", i), 32'(out_st.valid), 1);
            chk($sformatf("wrap_pkt%0d_data", i), out_st.data, 32'(i));
            @(posedge clk);
            #1;
            if (i == 15) chk("wrap_zero", 32'(pkt_count), 0);
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_final", 32'(pkt_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
